// File: rtl/quantser_ctrl_pkg.sv
// Shared definitions for the quantser job controller: parameter defaults,
// derived field widths and the controller state encoding.
package quantser_ctrl_pkg;

  localparam int BDIN_DEF     = 32;
  localparam int BDOUTMAX_DEF = 32;
  localparam int AWIDTH_DEF   = 9;
  localparam int CNTW_DEF     = 16;

  localparam int MAXBDIP = $clog2(BDIN_DEF);
  localparam int MAXBDOP = $clog2(BDOUTMAX_DEF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/quantser_ctrl_if.sv
// Job-request handshake bundle: the requester drives a job description,
// the controller answers with cfg_ready.
interface quantser_ctrl_if
  import quantser_ctrl_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int CNTW   = CNTW_DEF,
  parameter int MSBW   = MAXBDIP,
  parameter int BDW    = MAXBDOP
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [AWIDTH-1:0] cfg_baddr;
  logic [CNTW-1:0]   cfg_len;
  logic [MSBW-1:0]   cfg_msbidx;
  logic [BDW-1:0]    cfg_bdout;

  modport master (
    output cfg_valid, cfg_baddr, cfg_len, cfg_msbidx, cfg_bdout,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_baddr, cfg_len, cfg_msbidx, cfg_bdout,
    output cfg_ready
  );

endinterface

// File: rtl/quantser_ctrl.sv
// Job controller for an external quantser: reads words from a buffer, loads and
// starts the quantser, and frames the serial bits it shifts out for each word.
module quantser_ctrl
  import quantser_ctrl_pkg::*;
#(
  parameter  int BDIN     = BDIN_DEF,
  parameter  int BDOUTMAX = BDOUTMAX_DEF,
  parameter  int AWIDTH   = AWIDTH_DEF,
  parameter  int CNTW     = CNTW_DEF,
  localparam int MSBW     = $clog2(BDIN),
  localparam int BDW      = $clog2(BDOUTMAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  quantser_ctrl_if.slave    cfg,
  input  logic              abort,
  output logic              rd_en,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [BDIN-1:0]   rd_data,
  output logic              qs_clr,
  output logic              qs_start,
  output logic [BDIN-1:0]   qs_din,
  output logic [MSBW-1:0]   qs_msbidx,
  output logic [BDW-1:0]    qs_bdout,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [CNTW-1:0]   words_q, words_d;
  logic [BDW-1:0]    bit_q, bit_d;
  logic [MSBW-1:0]   msbidx_q, msbidx_d;
  logic [BDW-1:0]    bdout_q, bdout_d;
  logic [BDIN-1:0]   din_q, din_d;
  logic              err_q, err_d;
  logic              rstclr_q;
  logic              abclr_q;

  logic accept_s, reject_s, abort_s, last_bit_s, last_word_s;

  assign accept_s    = cfg.cfg_valid & cfg.cfg_ready;
  assign reject_s    = (cfg.cfg_len == '0) | (int'(cfg.cfg_bdout) > int'(cfg.cfg_msbidx));
  assign abort_s     = abort & (state_q != S_IDLE);
  assign last_bit_s  = (bit_q == bdout_q);
  assign last_word_s = (words_q == CNTW'(1));

  // Next-state and datapath update; an abort outside IDLE overrides everything.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    words_d  = words_q;
    bit_d    = bit_q;
    msbidx_d = msbidx_q;
    bdout_d  = bdout_q;
    din_d    = din_q;
    err_d    = err_q;
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            addr_d   = cfg.cfg_baddr;
            words_d  = cfg.cfg_len;
            msbidx_d = cfg.cfg_msbidx;
            bdout_d  = cfg.cfg_bdout;
            err_d    = reject_s;
            state_d  = reject_s ? S_DONE : S_FETCH;
          end else begin
            err_d = 1'b0;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          din_d   = rd_data;
          state_d = S_START;
        end
        S_START: begin
          bit_d   = '0;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          if (!last_bit_s) begin
            bit_d = bit_q + BDW'(1);
          end else if (last_word_s) begin
            state_d = S_DONE;
          end else begin
            // Address wraps naturally at the buffer size.
            words_d = words_q - CNTW'(1);
            addr_d  = addr_q + AWIDTH'(1);
            state_d = S_FETCH;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; rstclr_q keeps the quantser cleared one cycle past reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      words_q  <= '0;
      bit_q    <= '0;
      msbidx_q <= '0;
      bdout_q  <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
      rstclr_q <= 1'b1;
      abclr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      bit_q    <= bit_d;
      msbidx_q <= msbidx_d;
      bdout_q  <= bdout_d;
      din_q    <= din_d;
      err_q    <= err_d;
      rstclr_q <= 1'b0;
      abclr_q  <= abort_s;
    end
  end

  assign cfg.cfg_ready = (state_q == S_IDLE) & ~rstclr_q;
  assign busy          = (state_q != S_IDLE);
  assign rd_en         = (state_q == S_FETCH) & ~abort_s;
  assign rd_addr       = addr_q;
  assign qs_start      = (state_q == S_START) & ~abort_s;
  assign ser_valid     = (state_q == S_SHIFT) & ~abort_s;
  assign ser_last      = ser_valid & last_bit_s & last_word_s;
  assign done          = (state_q == S_DONE) & ~abort_s;
  assign err           = done & err_q;
  assign qs_clr        = rstclr_q | abclr_q;
  assign qs_din        = din_q;
  assign qs_msbidx     = msbidx_q;
  assign qs_bdout      = bdout_q;

endmodule

// File: tb/tb_quantser_ctrl.sv
// Bench for quantser_ctrl with a behavioural quantser and a 1-cycle-latency word buffer.
module tb_quantser_ctrl;
  import quantser_ctrl_pkg::*;

  typedef struct packed {
    logic [8:0]       baddr;
    logic [15:0]      len;
    logic [4:0]       msbidx;
    logic [4:0]       bdout;
    logic [3:0][31:0] w;
    logic             rej;
    logic             ab;
  } job_t;

  typedef struct packed {
    logic b;
    logic last;
  } bit_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        abort = 1'b0;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data = 32'd0;
  logic        qs_clr, qs_start;
  logic [31:0] qs_din;
  logic [4:0]  qs_msbidx, qs_bdout;
  logic        ser_valid, ser_last, busy, done, err;

  quantser_ctrl_if cfg_if ();

  quantser_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg_if),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .qs_clr    (qs_clr),
    .qs_start  (qs_start),
    .qs_din    (qs_din),
    .qs_msbidx (qs_msbidx),
    .qs_bdout  (qs_bdout),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [512];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Quantser: loads the word aligned so bit msbidx sits at the top, then shifts MSB-first.
  logic [31:0] qs_sr;
  logic        qs_dout;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         qs_sr <= 32'd0;
    else if (qs_clr)    qs_sr <= 32'd0;
    else if (qs_start)  qs_sr <= qs_din << (5'd31 - qs_msbidx);
    else if (ser_valid) qs_sr <= qs_sr << 1;
  end
  assign qs_dout = qs_sr[31];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_err = 1'b0;
  bit   mon_en = 1'b0;
  bit_t exp_q[$];
  logic [8:0] rdexp_q[$];
  job_t jobs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    bit_t       e;
    logic [8:0] a;
    if (mon_en) begin
      if (ser_valid) begin
        if (exp_q.size() == 0) chk("unexpected ser_valid", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("ser bit", 32'(qs_dout), 32'(e.b));
          chk("ser_last", 32'(ser_last), 32'(e.last));
        end
      end else if (ser_last) chk("ser_last without ser_valid", 32'd1, 32'd0);
      if (rd_en) begin
        if (rdexp_q.size() == 0) chk("unexpected rd_en", 32'd1, 32'd0);
        else begin
          a = rdexp_q.pop_front();
          chk("rd_addr", 32'(rd_addr), 32'(a));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
      end
    end
  end

  function automatic job_t mk(input logic [8:0] ba, input logic [15:0] ln,
                              input logic [4:0] ms, input logic [4:0] bd,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic rj, input logic ab);
    job_t j;
    j.baddr = ba; j.len = ln; j.msbidx = ms; j.bdout = bd;
    j.w[0] = w0; j.w[1] = w1; j.w[2] = w2; j.w[3] = w3;
    j.rej = rj; j.ab = ab;
    return j;
  endfunction

  // Writes the job words into the buffer and queues expected reads/bits (words < nw only).
  task automatic fill_push(input job_t j, input int nw, input int last_k);
    logic [8:0]  a;
    logic [31:0] wd;
    bit_t        e;
    for (int wi = 0; wi < 4; wi++) begin
      a = j.baddr + 9'(wi);
      mem[a] = j.w[wi];
      if (!j.rej && wi < int'(j.len) && wi < nw) begin
        rdexp_q.push_back(a);
        wd = j.w[wi];
        for (int k = 0; k <= int'(j.bdout); k++) begin
          if (wi < nw - 1 || k <= last_k) begin
            e.b = wd[int'(j.msbidx) - k];
            e.last = (wi == int'(j.len) - 1) && (k == int'(j.bdout));
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic start_job(input job_t j, output int acc);
    int n = 0;
    while (cfg_if.cfg_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("cfg_ready timeout", 32'd0, 32'd1);
    cfg_if.cfg_baddr  = j.baddr;
    cfg_if.cfg_len    = j.len;
    cfg_if.cfg_msbidx = j.msbidx;
    cfg_if.cfg_bdout  = j.bdout;
    cfg_if.cfg_valid  = 1'b1;
    abort = j.ab;
    acc = cyc;
    tick();
    cfg_if.cfg_valid = 1'b0;
    abort = 1'b0;
    chk("busy after accept", 32'(busy), 32'd1);
    if (j.ab) chk("qs_clr after idle abort", 32'(qs_clr), 32'd0);
  endtask

  task automatic run_job(input job_t j, input string tag, output int acc);
    int d0, lat, n;
    fill_push(j, 4, 31);
    d0  = done_cnt;
    lat = j.rej ? 1 : int'(j.len) * (int'(j.bdout) + 4) + 1;
    start_job(j, acc);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    if (done_cnt == d0) chk({tag, " done timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, " latency"}, 32'(done_cyc - acc), 32'(lat));
      chk({tag, " err"}, 32'(done_err), 32'(j.rej));
      chk({tag, " done pulse"}, 32'(done), 32'd0);
      chk({tag, " idle after done"}, 32'(busy), 32'd0);
    end
    chk({tag, " bits left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " reads left"}, 32'(rdexp_q.size()), 32'd0);
    chk({tag, " msbidx held"}, 32'(qs_msbidx), 32'(j.msbidx));
    chk({tag, " bdout held"}, 32'(qs_bdout), 32'(j.bdout));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " cfg_ready"}, 32'(cfg_if.cfg_ready), 32'd0);
    chk({tag, " rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, " qs_start"}, 32'(qs_start), 32'd0);
    chk({tag, " ser_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, " ser_last"}, 32'(ser_last), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " qs_din"}, qs_din, 32'd0);
    chk({tag, " qs_msbidx"}, 32'(qs_msbidx), 32'd0);
    chk({tag, " qs_bdout"}, 32'(qs_bdout), 32'd0);
    chk({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, " qs_clr"}, 32'(qs_clr), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    mon_en = 1'b1;
    chk_reset(tag);
    exp_q.delete();
    rdexp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    chk({tag, " qs_clr first cycle"}, 32'(qs_clr), 32'd1);
    chk({tag, " cfg_ready first cycle"}, 32'(cfg_if.cfg_ready), 32'd0);
    tick();
    chk({tag, " cfg_ready second cycle"}, 32'(cfg_if.cfg_ready), 32'd1);
    chk({tag, " qs_clr second cycle"}, 32'(qs_clr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   acc, acc2, d0;
    job_t ja, jm, jf;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_baddr  = 9'd0;
    cfg_if.cfg_len    = 16'd0;
    cfg_if.cfg_msbidx = 5'd0;
    cfg_if.cfg_bdout  = 5'd0;

    jobs[0] = mk(9'd0,   16'd1, 5'd7,  5'd3, 32'h0000_00A5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    jobs[1] = mk(9'd511, 16'd3, 5'd31, 5'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    jobs[2] = mk(9'd40,  16'd0, 5'd7,  5'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    jobs[3] = mk(9'd41,  16'd1, 5'd2,  5'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    jobs[4] = mk(9'd100, 16'd2, 5'd15, 5'd7, 32'h0000_1234, 32'h0000_BEEF, 32'd0, 32'd0, 1'b0, 1'b1);
    jobs[5] = mk(9'd200, 16'd4, 5'd20, 5'd20, 32'h0015_5555, 32'h000A_AAAA, 32'h001F_0F0F, 32'h0010_0001, 1'b0, 1'b0);

    #2;
    do_reset("reset");

    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle abort qs_clr", 32'(qs_clr), 32'd0);
    chk("idle abort busy", 32'(busy), 32'd0);
    chk("idle abort no done", 32'(done_cnt), 32'(d0));

    for (int i = 0; i < 6; i++) run_job(jobs[i], $sformatf("job%0d", i), acc);

    // Abort during the second shift cycle of word 2 of 4.
    ja = mk(9'd300, 16'd4, 5'd31, 5'd3, 32'hC000_0000, 32'h5000_0000, 32'hF000_0000, 32'h0F00_0000, 1'b0, 1'b0);
    fill_push(ja, 2, 0);
    d0 = done_cnt;
    start_job(ja, acc);
    repeat (11) tick();
    chk("abort pre ser_valid", 32'(ser_valid), 32'd1);
    abort = 1'b1;
    #1;
    chk("abort ser_valid gated", 32'(ser_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd1);
    tick();
    abort = 1'b0;
    chk("abort idle", 32'(busy), 32'd0);
    chk("abort qs_clr", 32'(qs_clr), 32'd1);
    chk("abort cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("abort bits left", 32'(exp_q.size()), 32'd0);
    chk("abort no done", 32'(done_cnt), 32'(d0));
    run_job(jobs[0], "post-abort", acc2);
    chk("post-abort accept cycle", 32'(acc2), 32'(acc + 13));
    chk("post-abort single done", 32'(done_cnt), 32'(d0 + 1));

    // Reset in the middle of a shift, then a full-depth job.
    jm = mk(9'd8, 16'd1, 5'd31, 5'd31, 32'h0000_00FF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    fill_push(jm, 4, 31);
    d0 = done_cnt;
    start_job(jm, acc);
    repeat (6) tick();
    #2;
    do_reset("mid-job reset");
    chk("mid-job reset no done", 32'(done_cnt), 32'(d0));
    jf = mk(9'd7, 16'd1, 5'd31, 5'd31, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    run_job(jf, "full-depth", acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
